// File: rtl/five_phase_clk_pkg.sv
// Shared definitions for the five-phase strobe generator and its consumers.
// Holds the phase count, the 3-bit Johnson-style state encodings and the
// phase index constants used to pick individual strobes out of Phases.
package five_phase_clk_pkg;

    localparam int NUM_PHASES = 5;
    localparam int STATE_W    = 3;

    // Legal states of the rotation; the three unused codes (001, 010, 101)
    // are illegal and recover through the normal next-state equations.
    typedef enum logic [STATE_W-1:0] {
        PH0 = 3'b000,
        PH1 = 3'b100,
        PH2 = 3'b110,
        PH3 = 3'b111,
        PH4 = 3'b011
    } phase_state_e;

    // Bit positions of each strobe within Phases.
    localparam int PH0_IDX = 0;
    localparam int PH1_IDX = 1;
    localparam int PH2_IDX = 2;
    localparam int PH3_IDX = 3;
    localparam int PH4_IDX = 4;

endpackage

// File: rtl/five_phase_clk.sv
// Five-phase one-hot strobe generator sequencing multi-cycle datapath stages.
// Latency: Phases is a combinational decode of the state register (0 extra cycles).
// Backpressure: none; the rotation free-runs one phase per CLK, RST restarts it.
//
// Ports:
//   CLK       in   system clock, all state changes on the rising edge
//   RST       in   synchronous active-high reset, forces phase 0
//   Phases    out  [4:0] one-hot phase strobes, bit i high during phase i
//   state_err out  high while the state register holds an illegal code
//                  (present only when FIVE_PHASE_CLK_STATE_CHECK_EN is defined)
module five_phase_clk
    import five_phase_clk_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    output logic [NUM_PHASES-1:0] Phases
`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
    ,
    output logic                  state_err
`endif
);

    logic [STATE_W-1:0] ps_q;
    logic [STATE_W-1:0] ps_d;

    // Johnson-style rotation 000 -> 100 -> 110 -> 111 -> 011 -> 000.
    // The same equations pull the illegal codes back into the loop within
    // one cycle (001 -> 100, 010 -> 100, 101 -> 110), so no explicit
    // recovery logic is needed.
    always_comb begin
        ps_d    = ps_q;
        ps_d[2] = ~(ps_q[1] & ps_q[0]);
        ps_d[1] = ps_q[2];
        ps_d[0] = ps_q[2] & ps_q[1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ps_q <= PH0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Full-code compares keep the illegal states decoding to all-zero.
    always_comb begin
        Phases          = '0;
        Phases[PH0_IDX] = (ps_q == PH0);
        Phases[PH1_IDX] = (ps_q == PH1);
        Phases[PH2_IDX] = (ps_q == PH2);
        Phases[PH3_IDX] = (ps_q == PH3);
        Phases[PH4_IDX] = (ps_q == PH4);
    end

`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
    always_comb begin
        state_err = (ps_q == 3'b001) || (ps_q == 3'b010) || (ps_q == 3'b101);
    end
`endif

endmodule

// File: tb/tb_five_phase_clk.sv
// Self-checking bench for five_phase_clk.
// Reference model is a phase index counter modulo 5; strobes are 1 << index.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_five_phase_clk;

    logic       CLK;
    logic       RST;
    logic [4:0] Phases;
`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
    logic       state_err;
`endif

    int pass_cnt;
    int total_cnt;
    int model_phase;   // reference: current phase index 0..4
    logic [2:0] force_val;

    five_phase_clk dut (
        .CLK    (CLK),
        .RST    (RST),
        .Phases (Phases)
`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
        ,
        .state_err (state_err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4:0] model_phases(input int ph);
        logic [4:0] v;
        v = 5'b00001 << ph;
        return v;
    endfunction

    // Drive RST for one rising edge, advance the model, land on the next falling edge.
    task automatic tick(input logic rst_val);
        RST = rst_val;
        @(posedge CLK);
        if (rst_val) model_phase = 0;
        else         model_phase = (model_phase + 1) % 5;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1);
            total_cnt++;
            if (Phases !== 5'b00001)
                $display("FAIL reset_phases edge=%0d got=%b exp=%b", i, Phases, 5'b00001);
            else pass_cnt++;
`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
            total_cnt++;
            if (state_err !== 1'b0)
                $display("FAIL reset_state_err got=%b exp=0", state_err);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_sequence();
        logic [4:0] exp_tab [5];
        exp_tab[0] = 5'b00010; exp_tab[1] = 5'b00100; exp_tab[2] = 5'b01000;
        exp_tab[3] = 5'b10000; exp_tab[4] = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            total_cnt++;
            if (Phases !== exp_tab[i])
                $display("FAIL sequence step=%0d got=%b exp=%b", i, Phases, exp_tab[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_long_run();
        for (int i = 0; i < 25; i++) begin
            tick(1'b0);
            total_cnt++;
            if (Phases !== model_phases(model_phase) || !$onehot(Phases))
                $display("FAIL long_run step=%0d got=%b exp=%b", i, Phases, model_phases(model_phase));
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        int budget;
        budget = 0;
        while (Phases !== 5'b01000 && budget < 10) begin
            tick(1'b0);
            budget++;
        end
        total_cnt++;
        if (Phases !== 5'b01000)
            $display("FAIL mid_reset_reach got=%b exp=%b", Phases, 5'b01000);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1);
            total_cnt++;
            if (Phases !== 5'b00001)
                $display("FAIL mid_reset_hold edge=%0d got=%b exp=%b", i, Phases, 5'b00001);
            else pass_cnt++;
        end
        tick(1'b0);
        total_cnt++;
        if (Phases !== 5'b00010)
            $display("FAIL mid_reset_release got=%b exp=%b", Phases, 5'b00010);
        else pass_cnt++;
    endtask

    task automatic test_illegal_recovery();
        logic [2:0] ill_tab [3];
        logic [4:0] nxt_tab [3];
        int         nxt_ph  [3];
        ill_tab[0] = 3'b001; nxt_tab[0] = 5'b00010; nxt_ph[0] = 1;
        ill_tab[1] = 3'b010; nxt_tab[1] = 5'b00010; nxt_ph[1] = 1;
        ill_tab[2] = 3'b101; nxt_tab[2] = 5'b00100; nxt_ph[2] = 2;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            force_val = ill_tab[i];
            force dut.ps_q = force_val;
            #1;
            total_cnt++;
            if (Phases !== 5'b00000)
                $display("FAIL illegal_decode state=%b got=%b exp=%b", ill_tab[i], Phases, 5'b00000);
            else pass_cnt++;
`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
            total_cnt++;
            if (state_err !== 1'b1)
                $display("FAIL illegal_state_err state=%b got=%b exp=1", ill_tab[i], state_err);
            else pass_cnt++;
`endif
            release dut.ps_q;
            @(posedge CLK);
            @(negedge CLK);
            model_phase = nxt_ph[i];
            total_cnt++;
            if (Phases !== nxt_tab[i])
                $display("FAIL illegal_recover state=%b got=%b exp=%b", ill_tab[i], Phases, nxt_tab[i]);
            else pass_cnt++;
`ifdef FIVE_PHASE_CLK_STATE_CHECK_EN
            total_cnt++;
            if (state_err !== 1'b0)
                $display("FAIL illegal_err_clear state=%b got=%b exp=0", ill_tab[i], state_err);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_reset_priority();
        // Reset on the phase-4 edge (which would otherwise wrap to phase 0).
        while (model_phase != 4) tick(1'b0);
        total_cnt++;
        if (Phases !== 5'b10000)
            $display("FAIL prio_at_ph4 got=%b exp=%b", Phases, 5'b10000);
        else pass_cnt++;
        tick(1'b1);
        total_cnt++;
        if (Phases !== 5'b00001)
            $display("FAIL prio_rst_from_ph4 got=%b exp=%b", Phases, 5'b00001);
        else pass_cnt++;
        // Reset on the phase-0 edge (which would otherwise advance to phase 1).
        tick(1'b1);
        total_cnt++;
        if (Phases !== 5'b00001)
            $display("FAIL prio_rst_from_ph0 got=%b exp=%b", Phases, 5'b00001);
        else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0);
            total_cnt++;
            if (Phases !== model_phases(i % 5))
                $display("FAIL prio_release step=%0d got=%b exp=%b", i, Phases, model_phases(i % 5));
            else pass_cnt++;
        end
    endtask

    task automatic test_random_reset();
        logic r;
        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 7) == 0);
            tick(r);
            total_cnt++;
            if (Phases !== model_phases(model_phase) || !$onehot(Phases))
                $display("FAIL random step=%0d rst=%b got=%b exp=%b", i, r, Phases, model_phases(model_phase));
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        model_phase = 0;
        force_val   = 3'b000;
        RST         = 1'b1;
        @(negedge CLK);
        test_reset();
        test_sequence();
        test_long_run();
        test_mid_reset();
        test_illegal_recovery();
        test_reset_priority();
        test_random_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/five_phase_clk.md
Name: five_phase_clk

Overview:
- Generates five mutually exclusive, one-hot phase strobes that rotate in a fixed 5-cycle sequence, one phase per CLK cycle.
- Sequences the multi-cycle datapath stages of the processor (fetch/decode/execute/memory/writeback style).
- Internally a 3-bit Johnson-style state register; outputs are a decode of the state.

Parameters:
- None. Phase count is fixed at 5 and state width is fixed at 3.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset, sampled on rising CLK.
- Phases  output  5  one-hot phase strobes; bit i high during phase i.

Behaviour:
- State register ps[2:0] is updated on posedge CLK only.
- Reset: if RST=1 at a rising edge, ps <= 000. While RST is held high, ps stays 000 and Phases = 5'b00001.
- Next-state equations (RST=0):
  - ns[2] = ~(ps[1] & ps[0])
  - ns[1] = ps[2]
  - ns[0] = ps[2] & ps[1]
- Legal cycle: 000 -> 100 -> 110 -> 111 -> 011 -> 000, period 5 cycles.
- Output decode is combinational from ps only, with no registered outputs and 0 extra latency:
  - Phases[0] = (ps==000)
  - Phases[1] = (ps==100)
  - Phases[2] = (ps==110)
  - Phases[3] = (ps==111)
  - Phases[4] = (ps==011)
- Illegal states (001, 010, 101) produce Phases = 00000 and self-recover by the same equations:
  - 001 -> 100
  - 010 -> 100
  - 101 -> 110
  - Recovery to a legal state takes at most 1 cycle.
- Exactly one Phases bit is high in every legal state; never more than one bit in any state.
- First rising edge after RST deasserts: ps 000 -> 100, so Phases[1] is asserted.
- Reset mid-sequence: from any state, RST=1 at an edge forces 000 on that edge. The sequence restarts at phase 0 with no partial-phase carryover.
- Power-up state before the first reset is undefined. Correct behaviour is required only after at least one reset edge.

Optional Feature:
- Macro: FIVE_PHASE_CLK_STATE_CHECK_EN
- Defined:
  - Adds output port state_err (1 bit).
  - state_err is high combinationally whenever ps is 001, 010 or 101.
  - state_err is 0 during and after reset.
- Not defined:
  - Port and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package five_phase_clk_pkg holds:
  - localparam NUM_PHASES = 5
  - 3-bit state typedef/enum with encodings PH0=000, PH1=100, PH2=110, PH3=111, PH4=011
  - phase index constants 0..4 for consumers
- No sub-module. Next-state logic and output decode live in one module.

Test Plan:
- Reset then run: hold RST=1 for 2 edges -> Phases=00001. Release -> over the next 5 edges Phases = 00010, 00100, 01000, 10000, 00001.
- Long run: 25 edges after release -> sequence repeats every 5 cycles; every sample has $onehot(Phases).
- Mid-sequence reset: assert RST while Phases=01000 -> Phases=00001 after that edge and while held. Release -> next value 00010.
- Illegal-state recovery: force ps to 001, 010 and 101 in turn:
  - Phases=00000 in each forced state.
  - Next edge gives 00010, 00010 and 00100 respectively.
  - With FIVE_PHASE_CLK_STATE_CHECK_EN defined, state_err=1 only while in the illegal state.
- Reset priority: RST=1 on the same edge as the ps=011 -> 000 transition, and on the ps=000 edge -> ps=000 either way, with no skipped phase after release.
